led_port_ctrl: RTL and testbench



---
 rtl/led_port_ctrl_pkg.sv | 20 ++
 rtl/led_tick_gen.sv | 48 ++++
 rtl/led_port_ctrl.sv | 102 ++++++++++
 tb/tb_led_port_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_port_ctrl_pkg.sv
// Shared definitions for the red LED write port: register offsets, mode encodings, LED width.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package led_port_ctrl_pkg;

    localparam int LED_WIDTH = 16;

    // Register offsets, shared by the write decode and the read mux.
    localparam int ADDR_LED_DATA = 0;
    localparam int ADDR_MODE     = 1;
    localparam int ADDR_PRESCALE = 2;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROT_L  = 2'd2,
        MODE_ROT_R  = 2'd3
    } mode_t;

endpackage

// File: rtl/led_tick_gen.sv
// Tick generator: 2^PRE_SHIFT pre-divider feeding a step counter compared against prescale.
// Latency: tick is combinational from the counters; period is (prescale+1)*2^PRE_SHIFT cycles.
// Backpressure: none; clear restarts both counters and masks a tick in the same cycle.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   clear    synchronous restart of pre-divider and step counter
//   prescale number of pre-divider wraps per tick, minus one
//   tick     one-cycle pulse in the cycle the step counter matches at a pre-divider wrap
module led_tick_gen #(
    parameter int PRE_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [PRE_SHIFT-1:0] pre_cnt;
    logic [15:0]          step_cnt;
    logic                 pre_wrap;
    logic                 step_match;

    assign pre_wrap   = (pre_cnt == '1);
    assign step_match = (step_cnt == prescale);

    // A register write in the same cycle wins over the tick: nothing downstream
    // may rotate or toggle on the cycle the counters are being restarted.
    assign tick = pre_wrap && step_match && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else if (clear) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_SHIFT'(1);
            if (pre_wrap) begin
                step_cnt <= step_match ? 16'd0 : step_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/led_port_ctrl.sv
// Memory-mapped LED write port: static, blinking or rotating 16-bit pattern at a programmable rate.
// Latency: LED_DATA write reaches data_out 2 cycles after we; rdata is 1 cycle after addr.
// Backpressure: none; every write is accepted, writes to unmapped offsets are dropped.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   we       single-cycle write strobe
//   addr     register offset for both write and read (0 pattern, 1 mode, 2 prescale)
//   wdata    write data
//   rdata    registered read data for addr, sampled every cycle
//   tick_out pattern-update tick pulse (debug)
//   data_out registered LED word to the red LED stage (raw bits, signed only for port typing)
module led_port_ctrl
    import led_port_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 4,
    parameter int          PRE_SHIFT      = 8,
    parameter logic [15:0] RESET_PRESCALE = 16'd19530
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [15:0]                 wdata,
    output logic [15:0]                 rdata,
    output logic                        tick_out,
    output logic signed [LED_WIDTH-1:0] data_out
);

    logic [LED_WIDTH-1:0] pattern;
    mode_t                mode;
    logic [15:0]          prescale;
    logic                 phase;
    logic                 wr_hit;
    logic                 tick;
    logic [15:0]          rd_mux;

    // Only offsets 0..2 are mapped; anything above is neither stored nor allowed
    // to restart the tick counters.
    assign wr_hit = we && (addr <= ADDR_WIDTH'(ADDR_PRESCALE));

    led_tick_gen #(
        .PRE_SHIFT (PRE_SHIFT)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (wr_hit),
        .prescale (prescale),
        .tick     (tick)
    );

    assign tick_out = tick;

    // Register file and pattern engine. A mapped write always restarts the
    // blink phase so software sees a known output right after any update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern  <= '0;
            mode     <= MODE_STATIC;
            prescale <= RESET_PRESCALE;
            phase    <= 1'b0;
        end else if (wr_hit) begin
            phase <= 1'b0;
            case (addr)
                ADDR_WIDTH'(ADDR_LED_DATA): pattern  <= wdata;
                ADDR_WIDTH'(ADDR_MODE):     mode     <= mode_t'(wdata[1:0]);
                default:                    prescale <= wdata;
            endcase
        end else if (tick) begin
            case (mode)
                MODE_BLINK: phase   <= ~phase;
                MODE_ROT_L: pattern <= {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
                MODE_ROT_R: pattern <= {pattern[0], pattern[LED_WIDTH-1:1]};
                default:    pattern <= pattern;
            endcase
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (addr)
            ADDR_WIDTH'(ADDR_LED_DATA): rd_mux = pattern;
            ADDR_WIDTH'(ADDR_MODE):     rd_mux = {14'd0, mode};
            ADDR_WIDTH'(ADDR_PRESCALE): rd_mux = prescale;
            default:                    rd_mux = 16'd0;
        endcase
    end

    // Output stage: one register behind pattern/phase/mode, and read data one
    // register behind addr (so a same-cycle write reads back the old value).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            rdata    <= '0;
        end else begin
            data_out <= (mode == MODE_BLINK && phase) ? '0 : pattern;
            rdata    <= rd_mux;
        end
    end

endmodule

// File: tb/tb_led_port_ctrl.sv
module tb_led_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        tick_out;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] exp_rd_q[$];
    logic [15:0] exp_do_q[$];

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_do;
    } vec_t;

    typedef struct {
        logic [15:0] pat;
        logic [15:0] mode;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } rot_t;

    vec_t vecs[15];
    rot_t rots[2];

    led_port_ctrl #(
        .ADDR_WIDTH     (4),
        .PRE_SHIFT      (2),
        .RESET_PRESCALE (16'd19530)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tick_out (tick_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [15:0] exp);
        addr = a;
        exp_rd_q.push_back(exp);
        step();
        check(name, rdata, exp_rd_q.pop_front());
    endtask

    // Steps at least once, then until tick_out is seen or the budget runs out.
    task automatic wait_tick(output int at);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick_out !== 1'b1 && n < 300);
        at = cyc;
    endtask

    initial begin
        int t;
        int prev;
        int w;
        int tk;
        int chg;
        logic [15:0] cur;

        // {we, addr, wdata, expected rdata, expected data_out} after the vector's edge.
        vecs[0]  = '{1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'd1,  16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 4'd2,  16'h0000, 16'h4C4A, 16'h0000};
        vecs[3]  = '{1'b1, 4'd0,  16'h00A5, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 4'd0,  16'h0000, 16'h00A5, 16'h00A5};
        vecs[5]  = '{1'b1, 4'd1,  16'hFFFE, 16'h0000, 16'h00A5};
        vecs[6]  = '{1'b0, 4'd1,  16'h0000, 16'h0002, 16'h00A5};
        vecs[7]  = '{1'b1, 4'd1,  16'h0000, 16'h0002, 16'h00A5};
        vecs[8]  = '{1'b1, 4'd5,  16'hBEEF, 16'h0000, 16'h00A5};
        vecs[9]  = '{1'b0, 4'd5,  16'h0000, 16'h0000, 16'h00A5};
        vecs[10] = '{1'b0, 4'd0,  16'h0000, 16'h00A5, 16'h00A5};
        vecs[11] = '{1'b0, 4'd15, 16'h0000, 16'h0000, 16'h00A5};
        vecs[12] = '{1'b1, 4'd2,  16'h0100, 16'h4C4A, 16'h00A5};
        vecs[13] = '{1'b0, 4'd2,  16'h0000, 16'h0100, 16'h00A5};
        vecs[14] = '{1'b0, 4'd1,  16'h0000, 16'h0000, 16'h00A5};

        rots[0] = '{16'h8001, 16'd2, 16'h0003, 16'h0006};
        rots[1] = '{16'h0001, 16'd3, 16'h8000, 16'h4000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 16'h0000);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_tick_out", tick_out, 1'b0);
        reset = 1'b1;
        tk = 0;
        repeat (2000) begin
            step();
            if (tick_out === 1'b1) tk++;
        end
        check("no_tick_after_reset", tk, 0);

        // Register map vectors
        for (int i = 0; i < 15; i++) begin
            we    = vecs[i].we;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            exp_rd_q.push_back(vecs[i].exp_rd);
            exp_do_q.push_back(vecs[i].exp_do);
            step();
            we = 1'b0;
            check($sformatf("vec%0d_rdata", i), rdata, exp_rd_q.pop_front());
            check($sformatf("vec%0d_data_out", i), data_out, exp_do_q.pop_front());
        end

        // Static: ticks still run (period 4) but the pattern never moves
        wr(4'd2, 16'd0);
        tk  = 0;
        chg = 0;
        repeat (40) begin
            step();
            if (tick_out === 1'b1) tk++;
            if (data_out !== 16'h00A5) chg++;
        end
        check("static_tick_count", tk, 10);
        check("static_data_out_changes", chg, 0);

        // Blink: prescale 3 -> period 16
        wr(4'd0, 16'hFFFF);
        wr(4'd2, 16'd3);
        wr(4'd1, 16'd1);
        prev = cyc;
        cur  = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            wait_tick(t);
            check($sformatf("blink_gap%0d", k), t - prev, (k == 0) ? 15 : 16);
            check($sformatf("blink_at_tick%0d", k), data_out, cur);
            cur = ~cur;
            exp_do_q.push_back(cur);
            step();
            step();
            check($sformatf("blink_after_tick%0d", k), data_out, exp_do_q.pop_front());
            prev = t;
        end

        // Rotation wrap in both directions, prescale 0
        for (int r = 0; r < 2; r++) begin
            wr(4'd2, 16'd0);
            wr(4'd0, rots[r].pat);
            wr(4'd1, rots[r].mode);
            addr = 4'd0;
            for (int j = 0; j < 2; j++) begin
                wait_tick(t);
                exp_do_q.push_back((j == 0) ? rots[r].exp1 : rots[r].exp2);
                step();
                step();
                cur = exp_do_q.pop_front();
                check($sformatf("rot%0d_step%0d_data_out", r, j), data_out, cur);
                check($sformatf("rot%0d_step%0d_rdata", r, j), rdata, cur);
            end
        end

        // Collision: write lands in the exact tick cycle
        wr(4'd2, 16'd3);
        wr(4'd0, 16'h0001);
        wr(4'd1, 16'd2);
        repeat (15) step();
        we    = 1'b1;
        addr  = 4'd0;
        wdata = 16'h1234;
        #1;
        check("collision_tick_suppressed", tick_out, 1'b0);
        step();
        we = 1'b0;
        w  = cyc;
        rd("collision_pattern_unrotated", 4'd0, 16'h1234);
        wait_tick(t);
        check("collision_next_tick_gap", t - w, 15);
        step();
        step();
        check("collision_rotate_after", data_out, 16'h2468);

        // Unmapped write: no state change, no counter restart
        prev = t;
        repeat (3) step();
        wr(4'd5, 16'hBEEF);
        wait_tick(t);
        check("invalid_write_no_restart", t - prev, 16);
        step();
        step();
        check("invalid_write_pattern", data_out, 16'h48D0);
        rd("invalid_write_mode", 4'd1, 16'h0002);
        rd("invalid_read_zero", 4'd5, 16'h0000);

        // Reset asserted mid-rotation
        step();
        #2;
        reset = 1'b0;
        #1;
        check("midreset_data_out", data_out, 16'h0000);
        check("midreset_rdata", rdata, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        rd("postreset_pattern", 4'd0, 16'h0000);
        rd("postreset_mode", 4'd1, 16'h0000);
        rd("postreset_prescale", 4'd2, 16'd19530);
        check("postreset_data_out", data_out, 16'h0000);
        tk = 0;
        repeat (2000) begin
            step();
            if (tick_out === 1'b1) tk++;
        end
        check("postreset_no_tick", tk, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
